rgb_frame_receiver: RTL

Sits between the Manchester decoder and the LED PWM stage. It takes the decoder's per-bit strobe, data and error outputs, hunts for a sync word, and deserializes a 30-bit RGB payload protected by one parity bit. It drives the three 10-bit PWM duty registers, which change only when a complete, parity-correct frame arrives. It also flags frame acceptance and rejection for status and debug.

---
 rtl/rgb_frame_receiver.sv | 145 ++++++++++++++
 1 files changed

// File: rtl/rgb_frame_receiver.sv
// Receives decoded Manchester bits, locks to a sync word and commits a
// parity-protected 30-bit RGB payload to the PWM duty registers.
module rgb_frame_receiver #(
   parameter int                    SYNC_WIDTH     = 8,
   parameter logic [SYNC_WIDTH-1:0] SYNC_PATTERN   = 8'hA5,
   parameter int                    CH_WIDTH       = 10,
   parameter int                    TIMEOUT_CYCLES = 1023,
   parameter int                    TO_WIDTH       = 10
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                in_data,
   input  logic                in_strobe,
   input  logic                in_error,
   output logic [CH_WIDTH-1:0] data_red,
   output logic [CH_WIDTH-1:0] data_green,
   output logic [CH_WIDTH-1:0] data_blue,
   output logic                frame_valid,
   output logic                frame_error,
   output logic                synced
);

   localparam int PAY_W = 3 * CH_WIDTH;
   localparam int CNT_W = $clog2(PAY_W + 1);
   localparam logic [CNT_W-1:0]    CNT_LAST = CNT_W'(PAY_W - 1);
   localparam logic [TO_WIDTH-1:0] TO_LAST  = TO_WIDTH'(TIMEOUT_CYCLES - 1);

   typedef enum logic [1:0] {HUNT, PAYLOAD, PARITY} state_t;

   state_t                state_q, state_d;
   logic [SYNC_WIDTH-1:0] sync_q, sync_d;
   logic [PAY_W-1:0]      pay_q, pay_d;
   logic [CNT_W-1:0]      cnt_q, cnt_d;
   logic [TO_WIDTH-1:0]   to_q, to_d;
   logic [CH_WIDTH-1:0]   red_q, red_d, green_q, green_d, blue_q, blue_d;
   logic                  fv_q, fv_d, fe_q, fe_d, synced_q, synced_d;
   logic [SYNC_WIDTH-1:0] sync_shift;

   assign sync_shift = {sync_q[SYNC_WIDTH-2:0], in_data};

   always_comb begin
      state_d = state_q;
      sync_d  = sync_q;
      pay_d   = pay_q;
      cnt_d   = cnt_q;
      to_d    = to_q;
      red_d   = red_q;
      green_d = green_q;
      blue_d  = blue_q;
      fv_d    = 1'b0;
      fe_d    = 1'b0;
      unique case (state_q)
         HUNT: begin
            to_d = '0;
            if (in_error) begin
               sync_d = '0;
            end else if (in_strobe) begin
               sync_d = sync_shift;
               if (sync_shift == SYNC_PATTERN) begin
                  state_d = PAYLOAD;
                  sync_d  = '0;
                  cnt_d   = '0;
               end
            end
         end
         PAYLOAD, PARITY: begin
            // Priority: decoder error, then strobe, then timeout expiry.
            if (in_error) begin
               fe_d    = 1'b1;
               state_d = HUNT;
               sync_d  = '0;
               pay_d   = '0;
               cnt_d   = '0;
               to_d    = '0;
            end else if (in_strobe) begin
               to_d = '0;
               if (state_q == PAYLOAD) begin
                  pay_d = {pay_q[PAY_W-2:0], in_data};
                  cnt_d = cnt_q + CNT_W'(1);
                  if (cnt_q == CNT_LAST) state_d = PARITY;
               end else begin
                  if ((^pay_q ^ in_data) == 1'b0) begin
                     red_d   = pay_q[3*CH_WIDTH-1:2*CH_WIDTH];
                     green_d = pay_q[2*CH_WIDTH-1:CH_WIDTH];
                     blue_d  = pay_q[CH_WIDTH-1:0];
                     fv_d    = 1'b1;
                  end else begin
                     fe_d = 1'b1;
                  end
                  state_d = HUNT;
                  sync_d  = '0;
                  cnt_d   = '0;
               end
            end else if (to_q == TO_LAST) begin
               fe_d    = 1'b1;
               state_d = HUNT;
               sync_d  = '0;
               pay_d   = '0;
               cnt_d   = '0;
               to_d    = '0;
            end else begin
               to_d = to_q + TO_WIDTH'(1);
            end
         end
         default: state_d = HUNT;
      endcase
      synced_d = (state_d != HUNT);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q  <= HUNT;
         sync_q   <= '0;
         pay_q    <= '0;
         cnt_q    <= '0;
         to_q     <= '0;
         red_q    <= '0;
         green_q  <= '0;
         blue_q   <= '0;
         fv_q     <= 1'b0;
         fe_q     <= 1'b0;
         synced_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         sync_q   <= sync_d;
         pay_q    <= pay_d;
         cnt_q    <= cnt_d;
         to_q     <= to_d;
         red_q    <= red_d;
         green_q  <= green_d;
         blue_q   <= blue_d;
         fv_q     <= fv_d;
         fe_q     <= fe_d;
         synced_q <= synced_d;
      end
   end

   assign data_red    = red_q;
   assign data_green  = green_q;
   assign data_blue   = blue_q;
   assign frame_valid = fv_q;
   assign frame_error = fe_q;
   assign synced      = synced_q;

endmodule
